// File: rtl/h264_mb_sequencer.sv
// Frame-level macroblock sequencer: slice/line framing, header request and
// raster-order macroblock requests, stalling at row/frame ends until the buffer drains.
module h264_mb_sequencer #(
    parameter int MBW = 11,
    parameter int MBH = 9,
    parameter int CW  = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic          INTER_REQ,
    output logic          HDR_REQ,
    input  logic          HDR_DONE,
    output logic          MB_REQ,
    input  logic          MB_ACK,
    input  logic          BUF_DONE,
    output logic          NEWSLICE,
    output logic          NEWLINE,
    output logic          INTER_FLAG,
    output logic [CW-1:0] MBX,
    output logic [CW-1:0] MBY,
    output logic          BUSY,
    output logic          FRAME_DONE
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SLICE  = 3'd1,
        ST_HEADER = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_LINE   = 3'd5,
        ST_FINISH = 3'd6
    } state_t;

    localparam logic [CW-1:0] LP_X_LAST = CW'(MBW - 1);
    localparam logic [CW-1:0] LP_Y_LAST = CW'(MBH - 1);
    localparam logic [CW-1:0] LP_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LP_ZERO   = {CW{1'b0}};

    state_t        r_state;
    logic          r_hdr_req;
    logic          r_mb_req;
    logic          r_newslice;
    logic          r_newline;
    logic          r_inter_flag;
    logic [CW-1:0] r_mbx;
    logic [CW-1:0] r_mby;
    logic          r_busy;
    logic          r_frame_done;

    // Sequencer FSM; every output is registered alongside the state it decodes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state      <= ST_IDLE;
            r_hdr_req    <= 1'b0;
            r_mb_req     <= 1'b0;
            r_newslice   <= 1'b0;
            r_newline    <= 1'b0;
            r_inter_flag <= 1'b0;
            r_mbx        <= LP_ZERO;
            r_mby        <= LP_ZERO;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (START) begin
                        r_state      <= ST_SLICE;
                        r_mbx        <= LP_ZERO;
                        r_mby        <= LP_ZERO;
                        r_inter_flag <= INTER_REQ;
                        r_newslice   <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SLICE: begin
                    r_newslice <= 1'b0;
                    r_hdr_req  <= 1'b1;
                    r_state    <= ST_HEADER;
                end
                ST_HEADER: begin
                    if (HDR_DONE) begin
                        r_hdr_req <= 1'b0;
                        r_mb_req  <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_state <= ST_HEADER;
                    end
                end
                ST_ISSUE: begin
                    if (MB_ACK) begin
                        if (r_mbx < LP_X_LAST) begin
                            r_mbx   <= r_mbx + LP_ONE;
                            r_state <= ST_ISSUE;
                        end else if (r_mby < LP_Y_LAST) begin
                            r_mb_req <= 1'b0;
                            r_state  <= ST_DRAIN;
                        end else begin
                            r_mb_req <= 1'b0;
                            r_state  <= ST_FINISH;
                        end
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                // The buffer must finish its trailing NXINC before NEWLINE clears left-valid.
                ST_DRAIN: begin
                    if (BUF_DONE) begin
                        r_mbx     <= LP_ZERO;
                        r_mby     <= r_mby + LP_ONE;
                        r_newline <= 1'b1;
                        r_state   <= ST_LINE;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_LINE: begin
                    r_newline <= 1'b0;
                    r_mb_req  <= 1'b1;
                    r_state   <= ST_ISSUE;
                end
                ST_FINISH: begin
                    if (BUF_DONE) begin
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_state <= ST_FINISH;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_hdr_req    <= 1'b0;
                    r_mb_req     <= 1'b0;
                    r_newslice   <= 1'b0;
                    r_newline    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    assign HDR_REQ    = r_hdr_req;
    assign MB_REQ     = r_mb_req;
    assign NEWSLICE   = r_newslice;
    assign NEWLINE    = r_newline;
    assign INTER_FLAG = r_inter_flag;
    assign MBX        = r_mbx;
    assign MBY        = r_mby;
    assign BUSY       = r_busy;
    assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_h264_mb_sequencer.sv
// Randomised bench for h264_mb_sequencer: three instances (11x9, 2x2, 1x1) driven by
// a protocol-level responder; expected coordinates and pulse counts come from raster arithmetic.
module tb_h264_mb_sequencer;

    logic       CLK;
    logic       RSTN;
    logic       start     [3];
    logic       inter_req [3];
    logic       hdr_done  [3];
    logic       mb_ack    [3];
    logic       buf_done  [3];
    logic       hdr_req   [3];
    logic       mb_req    [3];
    logic       newslice  [3];
    logic       newline   [3];
    logic       inter_flag[3];
    logic [7:0] mbx       [3];
    logic [7:0] mby       [3];
    logic       busy      [3];
    logic       frame_done[3];

    int n_chk  = 0;
    int n_pass = 0;
    int nl_cnt [3];
    int ns_cnt [3];
    int excl_bad [3];

    h264_mb_sequencer #(.MBW(11), .MBH(9), .CW(8)) u_dut_a (
        .CLK(CLK), .RSTN(RSTN), .START(start[0]), .INTER_REQ(inter_req[0]),
        .HDR_REQ(hdr_req[0]), .HDR_DONE(hdr_done[0]), .MB_REQ(mb_req[0]), .MB_ACK(mb_ack[0]),
        .BUF_DONE(buf_done[0]), .NEWSLICE(newslice[0]), .NEWLINE(newline[0]),
        .INTER_FLAG(inter_flag[0]), .MBX(mbx[0]), .MBY(mby[0]), .BUSY(busy[0]),
        .FRAME_DONE(frame_done[0])
    );

    h264_mb_sequencer #(.MBW(2), .MBH(2), .CW(8)) u_dut_b (
        .CLK(CLK), .RSTN(RSTN), .START(start[1]), .INTER_REQ(inter_req[1]),
        .HDR_REQ(hdr_req[1]), .HDR_DONE(hdr_done[1]), .MB_REQ(mb_req[1]), .MB_ACK(mb_ack[1]),
        .BUF_DONE(buf_done[1]), .NEWSLICE(newslice[1]), .NEWLINE(newline[1]),
        .INTER_FLAG(inter_flag[1]), .MBX(mbx[1]), .MBY(mby[1]), .BUSY(busy[1]),
        .FRAME_DONE(frame_done[1])
    );

    h264_mb_sequencer #(.MBW(1), .MBH(1), .CW(8)) u_dut_c (
        .CLK(CLK), .RSTN(RSTN), .START(start[2]), .INTER_REQ(inter_req[2]),
        .HDR_REQ(hdr_req[2]), .HDR_DONE(hdr_done[2]), .MB_REQ(mb_req[2]), .MB_ACK(mb_ack[2]),
        .BUF_DONE(buf_done[2]), .NEWSLICE(newslice[2]), .NEWLINE(newline[2]),
        .INTER_FLAG(inter_flag[2]), .MBX(mbx[2]), .MBY(mby[2]), .BUSY(busy[2]),
        .FRAME_DONE(frame_done[2])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Pulse counters and mutual-exclusion watch, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RSTN === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (newline[i] === 1'b1) nl_cnt[i] = nl_cnt[i] + 1;
                if (newslice[i] === 1'b1) ns_cnt[i] = ns_cnt[i] + 1;
                if ((newslice[i] & newline[i]) === 1'b1 || (hdr_req[i] & mb_req[i]) === 1'b1)
                    excl_bad[i] = excl_bad[i] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic noise(input int d);
        start[d]     = rbit();
        inter_req[d] = rbit();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; inter_req[i] = 1'b0; hdr_done[i] = 1'b0;
            mb_ack[i] = 1'b0; buf_done[i] = 1'b0;
        end
    endtask

    task automatic check_all_zero(input int d, input string tag);
        check_eq({tag, "_hdr_req"}, 32'(hdr_req[d]), 32'd0);
        check_eq({tag, "_mb_req"}, 32'(mb_req[d]), 32'd0);
        check_eq({tag, "_newslice"}, 32'(newslice[d]), 32'd0);
        check_eq({tag, "_newline"}, 32'(newline[d]), 32'd0);
        check_eq({tag, "_inter_flag"}, 32'(inter_flag[d]), 32'd0);
        check_eq({tag, "_mbx"}, 32'(mbx[d]), 32'd0);
        check_eq({tag, "_mby"}, 32'(mby[d]), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy[d]), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done[d]), 32'd0);
    endtask

    // Pulse every handshake input while idle: nothing may move.
    task automatic idle_noise(input int d, input int ex, input int ey, input logic inter);
        for (int c = 0; c < 6; c++) begin
            start[d] = 1'b0; inter_req[d] = rbit();
            hdr_done[d] = 1'b1; mb_ack[d] = 1'b1; buf_done[d] = rbit();
            @(negedge CLK);
            check_eq("idle_busy", 32'(busy[d]), 32'd0);
            check_eq("idle_hdr_req", 32'(hdr_req[d]), 32'd0);
            check_eq("idle_mb_req", 32'(mb_req[d]), 32'd0);
            check_eq("idle_pulses", 32'(newslice[d] | newline[d] | frame_done[d]), 32'd0);
            check_eq("idle_mbx", 32'(mbx[d]), 32'(ex));
            check_eq("idle_mby", 32'(mby[d]), 32'(ey));
            check_eq("idle_inter", 32'(inter_flag[d]), 32'(inter));
        end
        hdr_done[d] = 1'b0; mb_ack[d] = 1'b0; buf_done[d] = 1'b0;
    endtask

    // One frame of w x h macroblocks; hdr_d=0 / lfix<0 pick random delays; stop_at>=0 aborts before that ack.
    task automatic run_frame(input int d, input int w, input int h, input logic inter,
                             input int hdr_d, input int gap_max, input int lfix, input int stop_at);
        int ns0, nl0, ex0, dd, hcnt, gap, l, x, y;
        ns0 = ns_cnt[d]; nl0 = nl_cnt[d]; ex0 = excl_bad[d];
        start[d] = 1'b1; inter_req[d] = inter;
        @(negedge CLK);
        start[d] = 1'b0; inter_req[d] = ~inter;
        check_eq("start_newslice", 32'(newslice[d]), 32'd1);
        check_eq("start_busy", 32'(busy[d]), 32'd1);
        check_eq("start_mbx", 32'(mbx[d]), 32'd0);
        check_eq("start_mby", 32'(mby[d]), 32'd0);
        check_eq("start_inter", 32'(inter_flag[d]), 32'(inter));
        check_eq("start_hdr_req", 32'(hdr_req[d]), 32'd0);
        hdr_done[d] = 1'b1; mb_ack[d] = 1'b1; buf_done[d] = 1'b1;
        @(negedge CLK);
        mb_ack[d] = 1'b0;
        check_eq("hdr_req_on", 32'(hdr_req[d]), 32'd1);
        check_eq("newslice_off", 32'(newslice[d]), 32'd0);
        dd = (hdr_d > 0) ? hdr_d : int'($urandom_range(1, 4));
        hcnt = 0;
        for (int t = 0; t < 20 && hdr_req[d] === 1'b1; t++) begin
            hcnt++;
            hdr_done[d] = (hcnt == dd);
            mb_ack[d] = rbit(); buf_done[d] = rbit(); noise(d);
            @(negedge CLK);
        end
        hdr_done[d] = 1'b0; mb_ack[d] = 1'b0;
        check_eq("hdr_len", 32'(hcnt), 32'(dd));
        check_eq("mb_req_after_hdr", 32'(mb_req[d]), 32'd1);
        for (int idx = 0; idx < w * h; idx++) begin
            x = idx % w; y = idx / w;
            gap = int'($urandom_range(0, gap_max));
            for (int g = 0; g < gap; g++) begin
                mb_ack[d] = 1'b0; buf_done[d] = rbit(); hdr_done[d] = rbit(); noise(d);
                @(negedge CLK);
                check_eq("mb_req_hold", 32'(mb_req[d]), 32'd1);
            end
            hdr_done[d] = 1'b0;
            check_eq("ack_mbx", 32'(mbx[d]), 32'(x));
            check_eq("ack_mby", 32'(mby[d]), 32'(y));
            check_eq("frame_inter", 32'(inter_flag[d]), 32'(inter));
            if (idx == stop_at) begin
                mb_ack[d] = 1'b0;
                return;
            end
            mb_ack[d] = 1'b1; buf_done[d] = rbit(); noise(d);
            @(negedge CLK);
            mb_ack[d] = 1'b0;
            if (x < w - 1) begin
                check_eq("mb_req_next", 32'(mb_req[d]), 32'd1);
            end else if (y < h - 1) begin
                check_eq("mb_req_drain", 32'(mb_req[d]), 32'd0);
                l = (lfix >= 0) ? lfix : int'($urandom_range(0, 5));
                for (int i = 0; i < l; i++) begin
                    buf_done[d] = 1'b0; mb_ack[d] = rbit(); noise(d);
                    @(negedge CLK);
                    check_eq("drain_mb_req", 32'(mb_req[d]), 32'd0);
                    check_eq("drain_newline", 32'(newline[d]), 32'd0);
                end
                buf_done[d] = 1'b1; mb_ack[d] = 1'b0;
                @(negedge CLK);
                check_eq("newline_pulse", 32'(newline[d]), 32'd1);
                check_eq("line_mbx", 32'(mbx[d]), 32'd0);
                check_eq("line_mby", 32'(mby[d]), 32'(y + 1));
                check_eq("line_mb_req", 32'(mb_req[d]), 32'd0);
                buf_done[d] = rbit();
                @(negedge CLK);
                check_eq("newline_end", 32'(newline[d]), 32'd0);
                check_eq("line_mb_req_on", 32'(mb_req[d]), 32'd1);
            end else begin
                check_eq("finish_mb_req", 32'(mb_req[d]), 32'd0);
                check_eq("finish_busy", 32'(busy[d]), 32'd1);
                l = (lfix >= 0) ? lfix : int'($urandom_range(0, 5));
                for (int i = 0; i < l; i++) begin
                    buf_done[d] = 1'b0; mb_ack[d] = rbit(); noise(d);
                    @(negedge CLK);
                    check_eq("finish_wait_fd", 32'(frame_done[d]), 32'd0);
                    check_eq("finish_wait_busy", 32'(busy[d]), 32'd1);
                end
                buf_done[d] = 1'b1; mb_ack[d] = 1'b0;
                @(negedge CLK);
                start[d] = 1'b0; inter_req[d] = ~inter; buf_done[d] = 1'b0;
                check_eq("frame_done_pulse", 32'(frame_done[d]), 32'd1);
                check_eq("done_busy", 32'(busy[d]), 32'd0);
                check_eq("done_mbx", 32'(mbx[d]), 32'(w - 1));
                check_eq("done_mby", 32'(mby[d]), 32'(h - 1));
                check_eq("done_inter", 32'(inter_flag[d]), 32'(inter));
                @(negedge CLK);
                check_eq("frame_done_end", 32'(frame_done[d]), 32'd0);
                check_eq("idle_inter_hold", 32'(inter_flag[d]), 32'(inter));
                check_eq("newslice_count", 32'(ns_cnt[d] - ns0), 32'd1);
                check_eq("newline_count", 32'(nl_cnt[d] - nl0), 32'(h - 1));
                check_eq("exclusion", 32'(excl_bad[d] - ex0), 32'd0);
            end
        end
    endtask

    initial begin
        logic inter_r;
        for (int i = 0; i < 3; i++) begin
            nl_cnt[i] = 0; ns_cnt[i] = 0; excl_bad[i] = 0;
        end
        clear_inputs();
        RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 3; i++) check_all_zero(i, "reset");
        RSTN = 1'b1;
        @(negedge CLK);

        // 2x2: fixed header, back-to-back acks, BUF_DONE immediate; then a 20-cycle drain stall.
        run_frame(1, 2, 2, 1'b1, 3, 0, 0, -1);
        idle_noise(1, 1, 1, 1'b1);
        run_frame(1, 2, 2, 1'b0, 3, 0, 20, -1);
        idle_noise(1, 1, 1, 1'b0);

        // 1x1: single ack goes straight to FINISH, no NEWLINE.
        run_frame(2, 1, 1, 1'b1, 0, 2, -1, -1);
        idle_noise(2, 0, 0, 1'b1);

        // 11x9 randomised frames.
        inter_r = 1'b0;
        for (int f = 0; f < 2; f++) begin
            inter_r = rbit();
            run_frame(0, 11, 9, inter_r, 0, 3, -1, -1);
        end
        idle_noise(0, 10, 8, inter_r);

        // Abort mid-row at (5,3) with an asynchronous reset between clock edges.
        run_frame(0, 11, 9, 1'b1, 0, 1, -1, 3 * 11 + 5);
        check_eq("pre_reset_busy", 32'(busy[0]), 32'd1);
        #2;
        RSTN = 1'b0;
        #1;
        check_all_zero(0, "async_reset");
        clear_inputs();
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        check_all_zero(0, "post_reset");
        run_frame(0, 11, 9, 1'b0, 0, 2, -1, -1);
        run_frame(1, 2, 2, 1'b1, 0, 3, -1, -1);
        run_frame(2, 1, 1, 1'b0, 0, 3, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
